// File: rtl/draw_sprite_pkg.sv
// +----------------------------------------------------------------------+
// | Module : draw_sprite_pkg                                             |
// | Brief  : FSM state type, screen/colour defaults and a width helper.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package draw_sprite_pkg;

  localparam int unsigned C_SCREEN_W = 160;
  localparam int unsigned C_SCREEN_H = 120;
  localparam int unsigned C_COLOUR_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/draw_sprite_addr_gen.sv
// +----------------------------------------------------------------------+
// | Module : sprite_addr_gen                                             |
// | Brief  : Raster col/row counters, mirrored ROM address, last flag.   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module sprite_addr_gen
  import draw_sprite_pkg::*;
#(
  parameter int unsigned SPRITE_W = 21,
  parameter int unsigned SPRITE_H = 30,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned COL_W    = cnt_w(SPRITE_W),
  parameter int unsigned ROW_W    = cnt_w(SPRITE_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              hflip_i,
  input  logic              advance_i,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              hflip_q, hflip_d;

  logic              w_last_col;
  logic              w_last_row;
  logic [COL_W-1:0]  w_col_off;

  assign w_last_col = (col_q == COL_W'(SPRITE_W - 1));
  assign w_last_row = (row_q == ROW_W'(SPRITE_H - 1));

  // base_q tracks row*SPRITE_W incrementally so no multiplier is needed
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    hflip_d = hflip_q;
    if (load_i) begin
      col_d   = '0;
      row_d   = '0;
      base_d  = '0;
      hflip_d = hflip_i;
    end else if (advance_i) begin
      if (w_last_col) begin
        col_d = '0;
        if (w_last_row) begin
          row_d  = '0;
          base_d = '0;
        end else begin
          row_d  = row_q + ROW_W'(1);
          base_d = base_q + ADDR_W'(SPRITE_W);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      hflip_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      hflip_q <= hflip_d;
    end
  end

  assign w_col_off = hflip_q ? (COL_W'(SPRITE_W - 1) - col_q) : col_q;
  assign addr_o    = base_q + ADDR_W'(w_col_off);
  assign col_o     = col_q;
  assign row_o     = row_q;
  assign last_o    = w_last_col & w_last_row;

endmodule

`default_nettype wire

// File: rtl/draw_sprite.sv
// +----------------------------------------------------------------------+
// | Module : draw_sprite                                                 |
// | Brief  : Walks a sprite ROM and emits clipped VGA plot strobes.      |
// |          DRAW_SPRITE_TRANSP_EN suppresses plots of TRANSP_COLOUR.    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module draw_sprite
  import draw_sprite_pkg::*;
#(
  parameter int unsigned SPRITE_W = 21,
  parameter int unsigned SPRITE_H = 30,
  parameter int unsigned SCREEN_W = C_SCREEN_W,
  parameter int unsigned SCREEN_H = C_SCREEN_H,
  parameter int unsigned COLOUR_W = C_COLOUR_W,
  parameter int unsigned ADDR_W   = 10,
  parameter logic [COLOUR_W-1:0] TRANSP_COLOUR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          xin,
  input  logic [6:0]          yin,
  input  logic                hflip,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int unsigned COL_W = cnt_w(SPRITE_W);
  localparam int unsigned ROW_W = cnt_w(SPRITE_H);

`ifdef DRAW_SPRITE_TRANSP_EN
  localparam logic C_TRANSP_EN = 1'b1;
`else
  localparam logic C_TRANSP_EN = 1'b0;
`endif

  state_t state_q, state_d;

  logic [7:0] xin_q;
  logic [6:0] yin_q;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic       vis_q, vis_d;
  logic       valid_q, valid_d;

  logic             w_load;
  logic             w_adv;
  logic             w_last;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic [8:0]       w_xsum;
  logic [7:0]       w_ysum;
  logic             w_is_key;

  sprite_addr_gen #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .ADDR_W   (ADDR_W),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load_i    (w_load),
    .hflip_i   (hflip),
    .advance_i (w_adv),
    .col_o     (w_col),
    .row_o     (w_row),
    .addr_o    (rom_addr),
    .last_o    (w_last)
  );

  always_comb begin
    state_d = state_q;
    w_load  = 1'b0;
    w_adv   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_load  = 1'b1;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        w_adv = 1'b1;
        if (w_last) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sums are one bit wider than the screen coordinates so overflow clips
  assign w_xsum = {1'b0, xin_q} + 9'(w_col);
  assign w_ysum = {1'b0, yin_q} + 8'(w_row);

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    vis_d   = 1'b0;
    valid_d = 1'b0;
    if (w_adv) begin
      x_d     = w_xsum[7:0];
      y_d     = w_ysum[6:0];
      valid_d = 1'b1;
      vis_d   = (w_xsum < 9'(SCREEN_W)) && (w_ysum < 8'(SCREEN_H));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      xin_q   <= '0;
      yin_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      vis_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_load) begin
        xin_q <= xin;
        yin_q <= yin;
      end
      x_q     <= x_d;
      y_q     <= y_d;
      vis_q   <= vis_d;
      valid_q <= valid_d;
    end
  end

  // rom_q is the synchronous ROM's output register, already aligned with x_q/y_q
  assign w_is_key = (rom_q == TRANSP_COLOUR);
  assign colour   = valid_q ? rom_q : '0;
  assign plot     = vis_q & ~(C_TRANSP_EN & w_is_key);
  assign x        = x_q;
  assign y        = y_q;
  assign busy     = (state_q == S_DRAW) || (state_q == S_FLUSH);
  assign done     = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_draw_sprite.sv
// +----------------------------------------------------------------------+
// | Module : tb_draw_sprite                                              |
// | Brief  : Randomised draws checked against an arithmetic raster model.|
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_draw_sprite;

  localparam int SW   = 21;
  localparam int SH   = 30;
  localparam int NPIX = SW * SH;
  localparam int SCRW = 160;
  localparam int SCRH = 120;

`ifdef DRAW_SPRITE_TRANSP_EN
  localparam bit C_TRANSP_ON = 1'b1;
`else
  localparam bit C_TRANSP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       hflip = 1'b0;
  logic [7:0] xin = '0;
  logic [6:0] yin = '0;
  logic [9:0] rom_addr;
  logic [2:0] rom_q = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  logic [2:0] mem [NPIX];
  int n_checks = 0;
  int n_err    = 0;

  draw_sprite dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .xin      (xin),
    .yin      (yin),
    .hflip    (hflip),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= (rom_addr < NPIX) ? mem[rom_addr] : 3'b000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: pixel k of the raster is (k%SW, k/SW); mirrored column read when flipped
  function automatic int exp_addr(input int k, input bit hf);
    int col;
    int row;
    col = k % SW;
    row = k / SW;
    return row * SW + (hf ? (SW - 1 - col) : col);
  endfunction

  function automatic bit exp_vis(input int k, input int xs, input int ys, input bit hf);
    bit v;
    bit key;
    v   = ((xs + k % SW) < SCRW) && ((ys + k / SW) < SCRH);
    key = (mem[exp_addr(k, hf)] == 3'b000);
    if (C_TRANSP_ON) v = v && !key;
    return v;
  endfunction

  function automatic int exp_count(input int xs, input int ys, input bit hf);
    int n;
    n = 0;
    for (int k = 0; k < NPIX; k++) if (exp_vis(k, xs, ys, hf)) n++;
    return n;
  endfunction

  task automatic fill_mem();
    for (int a = 0; a < NPIX; a++) mem[a] = 3'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".addr"},   rom_addr, 0);
    check_eq({tag, ".x"},      x,        0);
    check_eq({tag, ".y"},      y,        0);
    check_eq({tag, ".colour"}, colour,   0);
    check_eq({tag, ".plot"},   plot,     0);
    check_eq({tag, ".busy"},   busy,     0);
    check_eq({tag, ".done"},   done,     0);
  endtask

  // Cycle i is the sample after edge i-1, start being taken at edge 0
  task automatic run_draw(input string tag, input logic [7:0] xs, input logic [6:0] ys,
                          input logic hf, input bit poke);
    int n_plot;
    int n_done;
    int k;
    bit ev;
    n_plot = 0;
    n_done = 0;
    @(negedge clk);
    xin = xs; yin = ys; hflip = hf; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= NPIX + 6; i++) begin
      check_eq($sformatf("%s.busy@%0d", tag, i), busy, (i <= NPIX + 1));
      check_eq($sformatf("%s.done@%0d", tag, i), done, (i == NPIX + 2));
      if (i <= NPIX)
        check_eq($sformatf("%s.addr@%0d", tag, i), rom_addr, exp_addr(i - 1, hf));
      if (i >= 2 && i <= NPIX + 1) begin
        k  = i - 2;
        ev = exp_vis(k, xs, ys, hf);
        check_eq($sformatf("%s.plot@%0d", tag, i), plot, ev);
        if (ev) begin
          check_eq($sformatf("%s.x@%0d", tag, i), x, xs + k % SW);
          check_eq($sformatf("%s.y@%0d", tag, i), y, ys + k / SW);
          check_eq($sformatf("%s.col@%0d", tag, i), colour, mem[exp_addr(k, hf)]);
        end
      end else begin
        check_eq($sformatf("%s.plot@%0d", tag, i), plot, 0);
      end
      if (plot) n_plot++;
      if (done) n_done++;
      xin   = 8'($urandom);
      yin   = 7'($urandom);
      hflip = 1'($urandom);
      start = (i <= NPIX + 2) && poke && ((i == 100) || ($urandom_range(0, 7) == 0));
      @(negedge clk);
    end
    start = 1'b0;
    check_eq({tag, ".plots"}, n_plot, exp_count(xs, ys, hf));
    check_eq({tag, ".dones"}, n_done, 1);
  endtask

  initial begin
    int n_done;
    int guard;
    fill_mem();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    run_draw("base", 8'd10, 7'd20, 1'b0, 1'b0);
    check_eq("base.total", exp_count(10, 20, 0), C_TRANSP_ON ? exp_count(10, 20, 0) : NPIX);
    fill_mem();
    run_draw("flip", 8'd0, 7'd0, 1'b1, 1'b0);
    fill_mem();
    run_draw("clip", 8'd150, 7'd100, 1'b0, 1'b1);
    fill_mem();
    for (int a = 0; a < SW; a++) mem[a] = 3'b000;
    run_draw("key", 8'd0, 7'd0, 1'b0, 1'b0);
    fill_mem();
    run_draw("poke", 8'd33, 7'd44, 1'b0, 1'b1);

    // Reset in the middle of a draw
    @(negedge clk);
    xin = 8'd5; yin = 7'd5; hflip = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 300; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_eq("midrst.dones", n_done, 0);
    check_eq("midrst.busy", busy, 0);
    run_draw("after", 8'd5, 7'd5, 1'b0, 1'b0);

    // Start held high across DONE re-arms from IDLE
    @(negedge clk);
    xin = 8'd1; yin = 7'd1; start = 1'b1;
    guard = 0;
    while (!done && guard < 800) begin
      @(negedge clk);
      guard++;
    end
    check_eq("hold.done_seen", done, 1);
    @(negedge clk);
    check_eq("hold.idle_gap", busy, 0);
    @(negedge clk);
    check_eq("hold.restart", busy, 1);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 800) begin
      @(negedge clk);
      guard++;
    end
    check_eq("hold.done2", done, 1);
    repeat (2) @(negedge clk);

    for (int r = 0; r < 3; r++) begin
      fill_mem();
      run_draw($sformatf("rnd%0d", r), 8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)),
               1'($urandom), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/draw_sprite.md
DRAW_SPRITE -- requirements
Module: draw_sprite

Interface
REQ-001 Parameter SPRITE_W, default 21, sprite width in pixels.
REQ-002 Parameter SPRITE_H, default 30, sprite height in pixels.
REQ-003 Parameter SCREEN_W, default 160, visible width; SCREEN_H, default 120, visible height.
REQ-004 Parameter COLOUR_W, default 3, colour bits; ADDR_W, default 10, ROM address bits (>= clog2(SPRITE_W*SPRITE_H)).
REQ-005 Parameter TRANSP_COLOUR, default 3'b000, transparency key (used only under REQ-024).
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  draw request, sampled only in IDLE.
REQ-009 xin  input  8  sprite top-left x; yin  input  7  sprite top-left y.
REQ-010 hflip  input  1  horizontal mirror, latched with start.
REQ-011 rom_addr  output  ADDR_W  sprite ROM address; rom_q  input  COLOUR_W  ROM data, valid one clk after rom_addr.
REQ-012 x  output  8; y  output  7; colour  output  COLOUR_W  pixel to plot, all registered.
REQ-013 plot  output  1  VGA write strobe, one pixel per high cycle.
REQ-014 busy  output  1  high in DRAW and FLUSH; done  output  1  single-cycle completion pulse.

Function
REQ-015 FSM states IDLE, DRAW, FLUSH, DONE; IDLE->DRAW on start; DRAW->FLUSH after last address; FLUSH->DONE; DONE->IDLE unconditionally.
REQ-016 On start in IDLE, xin, yin, hflip latched; col, row counters cleared; changes to xin/yin/hflip during busy have no effect.
REQ-017 In DRAW, one address per cycle, raster order: col 0..SPRITE_W-1 then row+1, rows 0..SPRITE_H-1.
REQ-018 rom_addr = row*SPRITE_W + col, or row*SPRITE_W + (SPRITE_W-1-col) when latched hflip=1.
REQ-019 Pixel pipeline depth one: x, y, colour, plot for address issued in cycle N appear in cycle N+1; FLUSH emits the final pixel.
REQ-020 x = xin+col, y = yin+row computed at 9/8 bits; pixel with sum >= SCREEN_W or >= SCREEN_H is clipped: plot=0, counters still advance, no wrap-around drawing.
REQ-021 Timing: start sampled at edge 0 -> plot candidates cycles 2..SPRITE_W*SPRITE_H+1 -> done high in cycle SPRITE_W*SPRITE_H+2 only.
REQ-022 start while busy or in DONE ignored; start held high in IDLE after DONE begins a new draw.

Reset
REQ-023 reset asserted at any time, including mid-draw: state=IDLE, counters=0, rom_addr=0, x=0, y=0, colour=0, plot=0, busy=0, done=0; no partial completion pulse.

Configuration
REQ-024 Macro DRAW_SPRITE_TRANSP_EN defined: plot=0 for pixels whose rom_q equals TRANSP_COLOUR (timing unchanged); undefined: every unclipped pixel plotted regardless of colour.

Structure
REQ-025 Shared package holds FSM state typedef, SCREEN_W/SCREEN_H defaults and COLOUR_W; module-specific parameters stay local.
REQ-026 One sub-module, sprite_addr_gen (col/row counters, hflip address, last-pixel flag); FSM and pixel pipeline in draw_sprite; ROM instantiated outside.

Verification
REQ-027 Defaults, start with xin=10,yin=20,hflip=0 -> 630 plot pulses, first x=10,y=20,rom_addr 0, last x=30,y=49, done in cycle 632.
REQ-028 hflip=1, xin=0,yin=0 -> first pixel x=0,y=0 carries ROM word 20; pixel x=20,y=0 carries word 0.
REQ-029 xin=150,yin=100 -> only cols 0..9 and rows 0..19 plotted (200 pulses), done still in cycle 632.
REQ-030 TRANSP_EN built, ROM words 0..20 = 3'b000 -> no plot on row 0; undefined build -> 21 plots on row 0.
REQ-031 reset asserted in cycle 300 of a draw -> all outputs 0 next sample, no done pulse; new start draws a full 630 pixels.
REQ-032 start pulsed again at cycle 100 with different xin -> ignored, coordinates unchanged, single done.
